r_type_issue_wb: RTL and testbench
==================================

Name: r_type_issue_wb

Overview:
- Sequencer and register file that feeds the R-type execute unit and retires its result: the producer/consumer end of the execute-unit interface (idata, rv1, rv2 out; R-type result in).
- Accepts one 32-bit instruction at a time through a valid/ready handshake and decodes rs1/rs2/rd.
- Reads a 32x32 architectural register file and drives operands to the execute unit.
- Captures the result, writes back to rd, and reports retirement.
- Sits between fetch and the R-type ALU in the multi-cycle bring-up core.

Parameters:
- XLEN, 32, data width of registers and operands
- NREG, 32, number of architectural registers (x0 hardwired to zero)
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_data  in  32  RISC-V instruction word
- instr_ready  out  1  block can accept an instruction
- ex_idata  out  32  instruction word to execute unit
- ex_rv1  out  XLEN  rs1 operand to execute unit
- ex_rv2  out  XLEN  rs2 operand to execute unit
- ex_result  in  XLEN  combinational R-type result from execute unit
- done  out  1  one-cycle pulse: instruction retired
- illegal  out  1  qualifies done: instruction rejected, no writeback
- wb_rd  out  5  destination register of retired instruction
- wb_data  out  XLEN  value written (0 when illegal or rd==0)
- retired_cnt  out  CNT_W  count of legal retired instructions
- dbg_addr  in  5  debug read address
- dbg_data  out  XLEN  combinational read of register dbg_addr

Behaviour:
- FSM states: IDLE, DECODE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch instr_data and go to DECODE.
  - instr_ready is 0 in all other states.
- DECODE:
  - Legal means opcode[6:0]==7'b0110011 AND one of:
    - funct7==7'b0000000 with any funct3;
    - funct7==7'b0100000 with funct3==000 (sub) or funct3==101 (sra).
  - Legal: latch regfile[rs1] and regfile[rs2] into operand registers (x0 reads 0), then go to EXEC.
  - Illegal: set illegal flag, then go to WB.
- EXEC:
  - ex_idata/ex_rv1/ex_rv2 are driven from the latched registers and are stable for the whole state.
  - Sample ex_result into the result register, then go to WB.
- WB:
  - Legal: write result to regfile[rd] if rd!=0; x0 writes are dropped.
  - done=1 for exactly this cycle; wb_rd=rd; wb_data=result (0 if rd==0 or illegal); illegal=flag.
  - Legal instructions increment retired_cnt, which wraps modulo 2^CNT_W.
  - Go to IDLE.
- Latency:
  - Legal: accept at edge N, done high in cycle N+3.
  - Illegal: done high in cycle N+2.
  - Next accept is possible at the cycle after done (IDLE); throughput is 1 instruction per 4 cycles.
- Outside the WB cycle: done=0, illegal=0, wb_rd=0, wb_data=0.
- ex_* outputs hold their last values outside EXEC. The execute unit is combinational, so this is harmless.
- dbg_data:
  - Combinational read of the register array, no write bypass.
  - A read of the register being written in WB returns the old value in that cycle and the new value from the next cycle.
  - Address 0 returns 0.
- rs1==rd or rs2==rd: operands are read in DECODE before the write in WB, so old values are used.
- Reset (asynchronous, any state):
  - State goes to IDLE and all registers x1..x31 go to 0.
  - Latched instruction, operands, result, illegal flag, retired_cnt and all outputs go to 0, except instr_ready=1 after release.
  - An in-flight instruction is abandoned with no writeback and no done.
- instr_data is sampled only on the handshake cycle; changes while not ready are ignored.

Test Plan:
- Reset, then accept add x3,x1,x2 (0x002081B3) after preloading x1=5, x2=7 through prior addi-free path (sequence of R ops from 0: e.g. via sub/or chain) -> done in cycle N+3, wb_rd=3, wb_data=12, retired_cnt=+1, dbg_addr=3 returns 12 the cycle after WB.
- sub with rd=x0 (0x40208033) -> done, wb_rd=0, wb_data=0, x0 remains 0, retired_cnt increments.
- Illegal word 0x00000013 (addi) and 0x4020C1B3 (funct7=0100000 with xor) -> done at N+2 with illegal=1, no register changes, retired_cnt unchanged.
- Back-to-back: instr_valid held high with 3 instructions -> instr_ready high only in IDLE, accepts spaced 4 cycles apart, each retires in order with correct values; a dependent instruction (rs1=previous rd) sees the updated value.
- Assert rst during EXEC -> no done pulse, all registers read 0 via dbg port, instr_ready=1 on the first cycle after rst deasserts.
- Counter wrap with CNT_W=2: retire 5 legal instructions -> retired_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/r_type_issue_wb.sv
// r_type_issue_wb: accepts one R-type instruction at a time, reads operands
// from the architectural register file, hands them to a combinational execute
// unit, and writes the result back. Each instruction takes four cycles:
// IDLE -> DECODE -> EXEC -> WB. An illegal word skips EXEC.
`timescale 1ns/1ps
module r_type_issue_wb #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [31:0]      instr_data,
   output logic             instr_ready,
   output logic [31:0]      ex_idata,
   output logic [XLEN-1:0]  ex_rv1,
   output logic [XLEN-1:0]  ex_rv2,
   input  logic [XLEN-1:0]  ex_result,
   output logic             done,
   output logic             illegal,
   output logic [4:0]       wb_rd,
   output logic [XLEN-1:0]  wb_data,
   output logic [CNT_W-1:0] retired_cnt,
   input  logic [4:0]       dbg_addr,
   output logic [XLEN-1:0]  dbg_data
);

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

   state_t           state_q;
   logic [31:0]      instr_q;
   logic [31:0]      ex_idata_q;
   logic [XLEN-1:0]  rv1_q;
   logic [XLEN-1:0]  rv2_q;
   logic [XLEN-1:0]  result_q;
   logic             bad_q;
   logic             done_q;
   logic             illegal_q;
   logic [4:0]       wb_rd_q;
   logic [XLEN-1:0]  wb_data_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  regs_q [NREG];

   // Instruction fields of the latched word
   logic [6:0] opcode;
   logic [4:0] rd;
   logic [2:0] funct3;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [6:0] funct7;
   logic       legal;
   logic       wr_en;

   assign opcode = instr_q[6:0];
   assign rd     = instr_q[11:7];
   assign funct3 = instr_q[14:12];
   assign rs1    = instr_q[19:15];
   assign rs2    = instr_q[24:20];
   assign funct7 = instr_q[31:25];

   // Base R-type ops, plus the two alternate encodings (sub, sra)
   assign legal = (opcode == 7'b0110011) &&
                  ((funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));

   // Writeback happens on the edge that leaves WB; x0 writes are dropped
   assign wr_en = (state_q == WB) && !bad_q && (rd != 5'd0);

   assign instr_ready = (state_q == IDLE);
   assign ex_idata    = ex_idata_q;
   assign ex_rv1      = rv1_q;
   assign ex_rv2      = rv2_q;
   assign done        = done_q;
   assign illegal     = illegal_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign retired_cnt = cnt_q;

   // Debug port reads the array directly: no bypass of an in-progress write
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

   // Register file: cleared on reset, loaded with the retiring result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[rd] <= result_q;
      end
   end

   // Sequencer: instruction latch, operand read, result capture, retire outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         instr_q    <= '0;
         ex_idata_q <= '0;
         rv1_q      <= '0;
         rv2_q      <= '0;
         result_q   <= '0;
         bad_q      <= 1'b0;
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         cnt_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (instr_valid) begin
                  instr_q <= instr_data;
                  state_q <= DECODE;
               end
            end
            DECODE: begin
               if (legal) begin
                  // Operands are read here, before any write of this instruction
                  ex_idata_q <= instr_q;
                  rv1_q      <= (rs1 == 5'd0) ? '0 : regs_q[rs1];
                  rv2_q      <= (rs2 == 5'd0) ? '0 : regs_q[rs2];
                  bad_q      <= 1'b0;
                  state_q    <= EXEC;
               end else begin
                  bad_q     <= 1'b1;
                  done_q    <= 1'b1;
                  illegal_q <= 1'b1;
                  wb_rd_q   <= rd;
                  wb_data_q <= '0;
                  state_q   <= WB;
               end
            end
            EXEC: begin
               result_q  <= ex_result;
               done_q    <= 1'b1;
               illegal_q <= 1'b0;
               wb_rd_q   <= rd;
               wb_data_q <= (rd == 5'd0) ? '0 : ex_result;
               state_q   <= WB;
            end
            WB: begin
               done_q    <= 1'b0;
               illegal_q <= 1'b0;
               wb_rd_q   <= '0;
               wb_data_q <= '0;
               if (!bad_q) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_r_type_issue_wb.sv
// Bench for r_type_issue_wb. The bench plays the execute unit: during EXEC it
// checks the operands and returns a chosen result. Expected retirements are
// queued by the driver and checked by an independent monitor.
`timescale 1ns/1ps
module tb_r_type_issue_wb;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             instr_valid = 1'b0;
   logic [31:0]      instr_data = '0;
   logic             instr_ready;
   logic [31:0]      ex_idata;
   logic [XLEN-1:0]  ex_rv1;
   logic [XLEN-1:0]  ex_rv2;
   logic [XLEN-1:0]  ex_result = '0;
   logic             done;
   logic             illegal;
   logic [4:0]       wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic [CNT_W-1:0] retired_cnt;
   logic [4:0]       dbg_addr = '0;
   logic [XLEN-1:0]  dbg_data;

   r_type_issue_wb #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .instr_ready (instr_ready),
      .ex_idata    (ex_idata),
      .ex_rv1      (ex_rv1),
      .ex_rv2      (ex_rv2),
      .ex_result   (ex_result),
      .done        (done),
      .illegal     (illegal),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .retired_cnt (retired_cnt),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] w;
      logic [4:0]  rd;
      logic [31:0] data;
      bit          ill;
      logic [31:0] rv1;
      logic [31:0] rv2;
      logic [31:0] alu;
      logic [1:0]  cnt;
      bit          hold;
      bit          gap;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          ill;
      logic [1:0]  cnt;
      logic [31:0] old_val;
      logic [31:0] new_val;
      int          acc;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mreg [32];
   vec_t        vecs [11];
   int          n_vec = 0;
   int          n_bad = 0;
   int          last_acc = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s", name);
   endtask

   // Offer one instruction, wait for the handshake, then act as execute unit
   task automatic issue(input vec_t v, input bit push);
      int   n;
      exp_t e;
      @(negedge clk);
      instr_valid = 1'b1;
      instr_data  = v.w;
      n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         fail_now("accept_timeout");
         instr_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!v.hold) instr_valid = 1'b0;
      instr_data = $urandom();
      if (v.gap) chk("accept_gap", cyc - last_acc, 4);
      last_acc = cyc;
      chk("ready_low_decode", {31'd0, instr_ready}, 0);
      if (push) begin
         e.rd      = v.rd;
         e.data    = v.data;
         e.ill     = v.ill;
         e.cnt     = v.cnt;
         e.acc     = cyc;
         e.old_val = mreg[v.rd];
         e.new_val = (v.ill || v.rd == 5'd0) ? e.old_val : v.data;
         mreg[v.rd] = e.new_val;
         sb.push_back(e);
      end
      if (!v.ill) begin
         @(posedge clk);
         #1;
         chk("ex_idata", ex_idata, v.w);
         chk("ex_rv1", ex_rv1, v.rv1);
         chk("ex_rv2", ex_rv2, v.rv2);
         ex_result = v.alu;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         fail_now("drain_timeout");
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // Monitor: compare each retirement against the queue head
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) continue;
         if (done) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_done");
               continue;
            end
            e = sb.pop_front();
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            chk("wb_data", wb_data, e.data);
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            // Edges from the accept edge to the WB cycle: DECODE, EXEC, WB
            chk("latency", cyc - e.acc, e.ill ? 1 : 2);
            dbg_addr = e.rd;
            #1;
            chk("dbg_old", dbg_data, e.old_val);
            @(negedge clk);
            chk("done_pulse", {31'd0, done}, 0);
            chk("dbg_new", dbg_data, e.new_val);
            chk("retired_cnt", {30'd0, retired_cnt}, {30'd0, e.cnt});
         end else begin
            chk("idle_outputs", {illegal, wb_rd, wb_data[25:0]} | {6'd0, wb_data[31:26] != 6'd0, 25'd0}, 0);
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin : stim
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      //            word          rd    data          ill  rv1     rv2     alu           cnt  hold gap
      vecs[0]  = '{32'h000000B3, 5'd1, 32'd5,        1'b0, 32'd0,  32'd0,  32'd5,        2'd1, 1'b0, 1'b0}; // add x1,x0,x0
      vecs[1]  = '{32'h00006133, 5'd2, 32'd7,        1'b0, 32'd0,  32'd0,  32'd7,        2'd2, 1'b0, 1'b0}; // or  x2,x0,x0
      vecs[2]  = '{32'h002081B3, 5'd3, 32'd12,       1'b0, 32'd5,  32'd7,  32'd12,       2'd3, 1'b0, 1'b0}; // add x3,x1,x2
      vecs[3]  = '{32'h40208033, 5'd0, 32'd0,        1'b0, 32'd5,  32'd7,  32'hFFFFFFFE, 2'd0, 1'b0, 1'b0}; // sub x0,x1,x2
      vecs[4]  = '{32'h00000013, 5'd0, 32'd0,        1'b1, 32'd0,  32'd0,  32'd0,        2'd0, 1'b0, 1'b0}; // addi (illegal)
      vecs[5]  = '{32'h4020C1B3, 5'd3, 32'd0,        1'b1, 32'd0,  32'd0,  32'd0,        2'd0, 1'b0, 1'b0}; // alt xor (illegal)
      vecs[6]  = '{32'h00118233, 5'd4, 32'd17,       1'b0, 32'd12, 32'd5,  32'd17,       2'd1, 1'b1, 1'b0}; // add x4,x3,x1
      vecs[7]  = '{32'h004202B3, 5'd5, 32'd34,       1'b0, 32'd17, 32'd17, 32'd34,       2'd2, 1'b1, 1'b1}; // add x5,x4,x4
      vecs[8]  = '{32'h4012D333, 5'd6, 32'd1,        1'b0, 32'd34, 32'd5,  32'd1,        2'd3, 1'b0, 1'b1}; // sra x6,x5,x1
      vecs[9]  = '{32'h001080B3, 5'd1, 32'd10,       1'b0, 32'd5,  32'd5,  32'd10,       2'd0, 1'b0, 1'b0}; // add x1,x1,x1
      vecs[10] = '{32'h00000133, 5'd2, 32'd9,        1'b0, 32'd0,  32'd0,  32'd9,        2'd1, 1'b0, 1'b0}; // add x2,x0,x0

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_cnt", {30'd0, retired_cnt}, 0);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", {31'd0, instr_ready}, 1);
      dbg_addr = 5'd5;
      #1;
      chk("rst_dbg_x5", dbg_data, 0);

      for (int i = 0; i < 10; i++) issue(vecs[i], 1'b1);
      drain();

      // Reset while an instruction sits in EXEC: it must be abandoned
      begin
         vec_t r;
         r = '{32'h001083B3, 5'd7, 32'd10, 1'b0, 32'd10, 32'd10, 32'd20, 2'd1, 1'b0, 1'b0};
         issue(r, 1'b0);
      end
      rst = 1'b1;
      #1;
      chk("rst_exec_done", {31'd0, done}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_exec_rst", {31'd0, instr_ready}, 1);
      chk("cnt_after_exec_rst", {30'd0, retired_cnt}, 0);
      chk("ex_rv1_after_rst", ex_rv1, 0);
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #1;
         chk("dbg_after_rst", dbg_data, 0);
         mreg[i] = '0;
      end
      repeat (4) @(negedge clk);

      issue(vecs[10], 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
